// File: rtl/usb_phy_tx.sv
// USB PHY transmitter: frames link-layer bytes with SYNC, serialises them
// LSB first with bit stuffing and NRZI, closes with EOP, and turns a cancel
// or an empty hold register into a bit-stuff-error abort followed by EOP.
module usb_phy_tx #(
  parameter int CLK_DIV   = 4,
  parameter bit LOW_SPEED = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_lp_sop,
  input  logic       tx_lp_eop,
  input  logic       tx_lp_valid,
  output logic       tx_lp_ready,
  input  logic [7:0] tx_lp_data,
  input  logic       tx_lp_cancle,
  output logic       usb_dp_o,
  output logic       usb_dn_o,
  output logic       usb_oe,
  output logic       tx_done,
  output logic       tx_underrun
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_ABORT,
    S_EOP_SE0,
    S_EOP_J
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [3:0]       r_bitcnt, w_bitcnt_nxt;
  logic [2:0]       r_ones, w_ones_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_shift_eop, w_shift_eop_nxt;
  logic [7:0]       r_hold, w_hold_nxt;
  logic             r_hold_eop, w_hold_eop_nxt;
  logic             r_hold_full, w_hold_full_nxt;
  logic             r_eop_acc, w_eop_acc_nxt;
  logic             r_cancel, w_cancel_nxt;
  logic             r_line, w_line_nxt;      // 1 = J, 0 = K
  logic             r_se0, w_se0_nxt;
  logic             r_oe, w_oe_nxt;
  logic             r_done, w_done_nxt;
  logic             r_underrun, w_underrun_nxt;
  logic             r_live;

  logic w_acc, w_bnd, w_load, w_abort, w_emit, w_bit;

  // Ready is held low for the first cycle after reset, then follows buffer state.
  assign tx_lp_ready = r_live && !r_hold_full && !r_eop_acc &&
                       (r_state == S_IDLE || r_state == S_SYNC || r_state == S_DATA);
  assign w_acc       = tx_lp_valid && tx_lp_ready;
  assign w_bnd       = (r_div == DIV_LAST);

  assign usb_oe      = r_oe;
  assign usb_dp_o    = !r_se0 && (r_line ^ LOW_SPEED);
  assign usb_dn_o    = !r_se0 && !(r_line ^ LOW_SPEED);
  assign tx_done     = r_done;
  assign tx_underrun = r_underrun;

  // Next-state and next-symbol decision; symbols change only at bit boundaries.
  always_comb begin
    w_state_nxt     = r_state;
    w_div_nxt       = r_div;
    w_bitcnt_nxt    = r_bitcnt;
    w_ones_nxt      = r_ones;
    w_shift_nxt     = r_shift;
    w_shift_eop_nxt = r_shift_eop;
    w_hold_nxt      = r_hold;
    w_hold_eop_nxt  = r_hold_eop;
    w_hold_full_nxt = r_hold_full;
    w_eop_acc_nxt   = r_eop_acc;
    w_cancel_nxt    = r_cancel;
    w_line_nxt      = r_line;
    w_se0_nxt       = r_se0;
    w_oe_nxt        = r_oe;
    w_done_nxt      = 1'b0;
    w_underrun_nxt  = 1'b0;
    w_load          = 1'b0;
    w_abort         = 1'b0;
    w_emit          = 1'b0;
    w_bit           = 1'b0;

    if (r_state != S_IDLE) begin
      w_div_nxt = w_bnd ? '0 : r_div + 1'b1;
    end

    // While a packet is live, accepted beats fill the hold register (sop ignored)
    // and a cancel request is latched until the next bit boundary.
    if (r_state == S_SYNC || r_state == S_DATA) begin
      if (tx_lp_cancle) begin
        w_cancel_nxt = 1'b1;
      end
      if (w_acc) begin
        w_hold_nxt      = tx_lp_data;
        w_hold_eop_nxt  = tx_lp_eop;
        w_hold_full_nxt = 1'b1;
        if (tx_lp_eop) begin
          w_eop_acc_nxt = 1'b1;
        end
      end
    end

    case (r_state)
      S_IDLE: begin
        // Beats without sop are simply dropped here.
        if (w_acc && tx_lp_sop) begin
          w_hold_nxt      = tx_lp_data;
          w_hold_eop_nxt  = tx_lp_eop;
          w_hold_full_nxt = 1'b1;
          w_eop_acc_nxt   = tx_lp_eop;
          w_state_nxt     = S_SYNC;
          w_bitcnt_nxt    = '0;
          w_div_nxt       = '0;
          w_oe_nxt        = 1'b1;
          w_cancel_nxt    = 1'b0;
          w_emit          = 1'b1;
          w_bit           = 1'b0;
        end
      end
      S_SYNC: begin
        if (w_bnd) begin
          if (r_cancel) begin
            w_abort = 1'b1;
          end else if (r_bitcnt != 4'd7) begin
            // SYNC pattern is seven 0s then a single 1.
            w_bitcnt_nxt = r_bitcnt + 4'd1;
            w_emit       = 1'b1;
            w_bit        = (r_bitcnt == 4'd6);
          end else if (r_hold_full) begin
            w_load = 1'b1;
          end else begin
            w_underrun_nxt = 1'b1;
            w_abort        = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (w_bnd) begin
          if (r_cancel) begin
            w_abort = 1'b1;
          end else if (r_ones == 3'd6) begin
            // Stuffed 0: the shift register does not advance.
            w_emit = 1'b1;
            w_bit  = 1'b0;
          end else if (r_bitcnt != 4'd8) begin
            w_emit       = 1'b1;
            w_bit        = r_shift[0];
            w_shift_nxt  = {1'b0, r_shift[7:1]};
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end else if (r_shift_eop) begin
            w_state_nxt  = S_EOP_SE0;
            w_se0_nxt    = 1'b1;
            w_bitcnt_nxt = '0;
          end else if (r_hold_full) begin
            w_load = 1'b1;
          end else begin
            w_underrun_nxt = 1'b1;
            w_abort        = 1'b1;
          end
        end
      end
      S_ABORT: begin
        // Eight held bit times of 1s form the deliberate stuff error.
        w_hold_full_nxt = 1'b0;
        if (w_bnd) begin
          if (r_bitcnt == 4'd7) begin
            w_state_nxt  = S_EOP_SE0;
            w_se0_nxt    = 1'b1;
            w_bitcnt_nxt = '0;
          end else begin
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end
        end
      end
      S_EOP_SE0: begin
        if (w_bnd) begin
          if (r_bitcnt == 4'd1) begin
            w_state_nxt  = S_EOP_J;
            w_se0_nxt    = 1'b0;
            w_line_nxt   = 1'b1;
            w_bitcnt_nxt = '0;
          end else begin
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end
        end
      end
      S_EOP_J: begin
        if (w_bnd) begin
          w_state_nxt   = S_IDLE;
          w_oe_nxt      = 1'b0;
          w_done_nxt    = 1'b1;
          w_line_nxt    = 1'b1;
          w_div_nxt     = '0;
          w_bitcnt_nxt  = '0;
          w_eop_acc_nxt = 1'b0;
          w_cancel_nxt  = 1'b0;
          w_ones_nxt    = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Move the held byte into the shift register and send its first bit.
    if (w_load) begin
      w_state_nxt     = S_DATA;
      w_shift_nxt     = {1'b0, r_hold[7:1]};
      w_shift_eop_nxt = r_hold_eop;
      w_hold_full_nxt = 1'b0;
      w_bitcnt_nxt    = 4'd1;
      w_emit          = 1'b1;
      w_bit           = r_hold[0];
    end

    // Abort keeps the line where it is; any pending stuff bit is dropped.
    if (w_abort) begin
      w_state_nxt     = S_ABORT;
      w_bitcnt_nxt    = '0;
      w_ones_nxt      = '0;
      w_cancel_nxt    = 1'b0;
      w_hold_full_nxt = 1'b0;
    end

    // NRZI: a 0 toggles the line, a 1 holds it and extends the run of ones.
    if (w_emit) begin
      if (w_bit) begin
        w_ones_nxt = r_ones + 3'd1;
      end else begin
        w_line_nxt = ~r_line;
        w_ones_nxt = '0;
      end
    end
  end

  // State and datapath registers; reset truncates any packet without EOP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_bitcnt    <= '0;
      r_ones      <= '0;
      r_shift     <= '0;
      r_shift_eop <= 1'b0;
      r_hold      <= '0;
      r_hold_eop  <= 1'b0;
      r_hold_full <= 1'b0;
      r_eop_acc   <= 1'b0;
      r_cancel    <= 1'b0;
      r_line      <= 1'b1;
      r_se0       <= 1'b0;
      r_oe        <= 1'b0;
      r_done      <= 1'b0;
      r_underrun  <= 1'b0;
      r_live      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_div       <= w_div_nxt;
      r_bitcnt    <= w_bitcnt_nxt;
      r_ones      <= w_ones_nxt;
      r_shift     <= w_shift_nxt;
      r_shift_eop <= w_shift_eop_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_eop  <= w_hold_eop_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_eop_acc   <= w_eop_acc_nxt;
      r_cancel    <= w_cancel_nxt;
      r_line      <= w_line_nxt;
      r_se0       <= w_se0_nxt;
      r_oe        <= w_oe_nxt;
      r_done      <= w_done_nxt;
      r_underrun  <= w_underrun_nxt;
      r_live      <= 1'b1;
    end
  end

endmodule
